// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss handler for the data cache. When the cache raises Miss, the block
// address is latched and eight word reads are issued to main memory on
// consecutive cycles. Each returned word is written straight into the cache
// data array in the same cycle it arrives. After the last word, MetaData_WE
// pulses for one cycle so the cache installs tag, valid and LRU bits. Busy
// covers the whole fill and is ORed into the pipeline stall.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   Miss         in   cache miss (read or write without hit)
//   Miss_Addr    in   CPU byte address of the missing access
//   Mem_Data     in   memory read data
//   Mem_Valid    in   Mem_Data valid; responses return in request order
//   Mem_En       out  memory read request strobe, one word per cycle
//   Mem_Addr     out  memory read byte address
//   Addr_FSM     out  cache fill address (word select in bits [3:1])
//   DataIn_FSM   out  cache fill data
//   Data_WE      out  cache data-array write enable
//   MetaData_WE  out  cache metadata write enable (one-cycle pulse)
//   Busy         out  fill in progress
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int OFFSET_W    = 3,
   parameter int ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Miss,
   input  logic [ADDR_W-1:0] Miss_Addr,
   input  logic [15:0]       Mem_Data,
   input  logic              Mem_Valid,
   output logic              Mem_En,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [ADDR_W-1:0] Addr_FSM,
   output logic [15:0]       DataIn_FSM,
   output logic              Data_WE,
   output logic              MetaData_WE,
   output logic              Busy
);

   // Block base is everything above the word offset and the byte bit.
   localparam int BASE_W = ADDR_W - OFFSET_W - 1;
   localparam int CNT_W  = OFFSET_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      META = 2'd2
   } state_t;

   state_t            state_reg,  state_next;
   logic [BASE_W-1:0] base_reg,   base_next;
   logic [CNT_W-1:0]  icnt_reg,   icnt_next;
   logic [CNT_W-1:0]  rcnt_reg,   rcnt_next;
   logic [15:0]       data_reg,   data_next;

   // The word offset and byte bit of the missing address are irrelevant:
   // the fill always starts at offset 0.
   logic unused_miss_low;
   assign unused_miss_low = &{1'b0, Miss_Addr[OFFSET_W:0]};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         base_reg  <= '0;
         icnt_reg  <= '0;
         rcnt_reg  <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         base_reg  <= base_next;
         icnt_reg  <= icnt_next;
         rcnt_reg  <= rcnt_next;
         data_reg  <= data_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      base_next   = base_reg;
      icnt_next   = icnt_reg;
      rcnt_next   = rcnt_reg;
      data_next   = data_reg;

      Mem_En      = 1'b0;
      Mem_Addr    = '0;
      Addr_FSM    = '0;
      DataIn_FSM  = data_reg;   // fill data holds its last written value
      Data_WE     = 1'b0;
      MetaData_WE = 1'b0;
      Busy        = 1'b0;

      unique case (state_reg)
         IDLE: begin
            // Stall must start in the miss cycle itself, before the
            // state register has moved.
            Busy = Miss;
            if (Miss) begin
               base_next  = Miss_Addr[ADDR_W-1:OFFSET_W+1];
               icnt_next  = '0;
               rcnt_next  = '0;
               state_next = FILL;
            end
         end

         FILL: begin
            Busy     = 1'b1;
            Mem_Addr = {base_reg, icnt_reg[OFFSET_W-1:0], 1'b0};
            Addr_FSM = {base_reg, rcnt_reg[OFFSET_W-1:0], 1'b0};

            // Requests go out back to back until all words are asked for.
            if (icnt_reg < CNT_FULL) begin
               Mem_En    = 1'b1;
               icnt_next = icnt_reg + CNT_ONE;
            end

            // Responses arrive in order, so the receive count is the
            // offset of the word being written. Excess responses beyond
            // the block are dropped.
            if (Mem_Valid && (rcnt_reg < CNT_FULL)) begin
               Data_WE    = 1'b1;
               DataIn_FSM = Mem_Data;
               data_next  = Mem_Data;
               rcnt_next  = rcnt_reg + CNT_ONE;
               if (rcnt_reg == CNT_LAST) begin
                  state_next = META;
               end
            end
         end

         META: begin
            Busy        = 1'b1;
            MetaData_WE = 1'b1;
            Addr_FSM    = {base_reg, {(OFFSET_W + 1){1'b0}}};
            state_next  = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        Miss;
   logic [15:0] Miss_Addr;
   logic [15:0] Mem_Data;
   logic        Mem_Valid;
   logic        Mem_En;
   logic [15:0] Mem_Addr;
   logic [15:0] Addr_FSM;
   logic [15:0] DataIn_FSM;
   logic        Data_WE;
   logic        MetaData_WE;
   logic        Busy;

   int compared   = 0;
   int mismatched = 0;

   cache_fill_fsm #(
      .BLOCK_WORDS (8),
      .OFFSET_W    (3),
      .ADDR_W      (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Miss        (Miss),
      .Miss_Addr   (Miss_Addr),
      .Mem_Data    (Mem_Data),
      .Mem_Valid   (Mem_Valid),
      .Mem_En      (Mem_En),
      .Mem_Addr    (Mem_Addr),
      .Addr_FSM    (Addr_FSM),
      .DataIn_FSM  (DataIn_FSM),
      .Data_WE     (Data_WE),
      .MetaData_WE (MetaData_WE),
      .Busy        (Busy)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // 2 units later, well away from either edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [51:0] out_vec();
      return {Mem_En, Data_WE, MetaData_WE, Busy, Mem_Addr, Addr_FSM, DataIn_FSM};
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      Miss = 1'b0; Miss_Addr = 16'h0000; Mem_Data = 16'h0000; Mem_Valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      compared++;
      if (out_vec() !== 52'h0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %h expected 0", out_vec());
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         Mem_Valid = c[0];
         Mem_Data  = 16'hFFFF;
         #2;
         compared++;
         if (out_vec() !== 52'h0) begin
            mismatched++;
            $display("FAIL idle_outputs cycle %0d: got %h expected 0", c, out_vec());
         end
         step();
      end
      Mem_Valid = 1'b0;
      $display("test_reset: 20 idle cycles with spurious Mem_Valid");
   endtask

   // ------------------------------------------------------------------
   // Miss at 3A46, memory latency 4: requests 1..8, data 5..12, META 13.
   task automatic test_basic_fill();
      for (int c = 0; c <= 14; c++) begin
         Miss      = (c <= 13);
         Miss_Addr = 16'h3A46;
         Mem_Valid = (c >= 5 && c <= 12);
         Mem_Data  = Mem_Valid ? 16'(16'hD000 + c - 5) : 16'h0BAD;
         #2;
         compared++;
         if (Mem_En !== (c >= 1 && c <= 8)) begin
            mismatched++;
            $display("FAIL basic_mem_en cycle %0d: got %b", c, Mem_En);
         end
         if (c >= 1 && c <= 8) begin
            compared++;
            if (Mem_Addr !== 16'(16'h3A40 + 2 * (c - 1))) begin
               mismatched++;
               $display("FAIL basic_mem_addr cycle %0d: got %h expected %h", c, Mem_Addr, 16'(16'h3A40 + 2 * (c - 1)));
            end
         end
         compared++;
         if (Data_WE !== (c >= 5 && c <= 12)) begin
            mismatched++;
            $display("FAIL basic_data_we cycle %0d: got %b", c, Data_WE);
         end
         if (c >= 5 && c <= 12) begin
            compared++;
            if ({Addr_FSM, DataIn_FSM} !== {16'(16'h3A40 + 2 * (c - 5)), 16'(16'hD000 + c - 5)}) begin
               mismatched++;
               $display("FAIL basic_fill_word cycle %0d: got %h/%h expected %h/%h", c, Addr_FSM, DataIn_FSM,
                        16'(16'h3A40 + 2 * (c - 5)), 16'(16'hD000 + c - 5));
            end
            $display("basic fill: word addr %h data %h", Addr_FSM, DataIn_FSM);
         end
         compared++;
         if (MetaData_WE !== (c == 13)) begin
            mismatched++;
            $display("FAIL basic_meta_we cycle %0d: got %b", c, MetaData_WE);
         end
         if (c == 13) begin
            compared++;
            if (Addr_FSM !== 16'h3A40) begin
               mismatched++;
               $display("FAIL basic_meta_addr: got %h expected 3a40", Addr_FSM);
            end
         end
         compared++;
         if (Busy !== (c <= 13)) begin
            mismatched++;
            $display("FAIL basic_busy cycle %0d: got %b", c, Busy);
         end
         if (c == 14) begin
            compared++;
            if (DataIn_FSM !== 16'hD007) begin
               mismatched++;
               $display("FAIL basic_data_hold: got %h expected d007", DataIn_FSM);
            end
         end
         step();
      end
   endtask

   // ------------------------------------------------------------------
   // Words arrive at cycles 3,4,5 then 9..13 (three idle cycles between
   // words 2 and 3). An excess response lands in META and spurious ones
   // in IDLE afterwards.
   task automatic test_stalled_memory();
      logic [18:0] word_mask;
      int k;
      int we_count;
      word_mask = 19'h03E38;
      k = 0;
      we_count = 0;
      for (int c = 0; c <= 18; c++) begin
         Miss      = (c <= 14);
         Miss_Addr = 16'h1234;
         Mem_Valid = word_mask[c] || (c >= 14);
         Mem_Data  = word_mask[c] ? 16'(16'hA000 + k) : 16'hEEEE;
         #2;
         if (Data_WE === 1'b1) we_count++;
         compared++;
         if (Data_WE !== word_mask[c]) begin
            mismatched++;
            $display("FAIL stall_data_we cycle %0d: got %b expected %b", c, Data_WE, word_mask[c]);
         end
         if (word_mask[c]) begin
            compared++;
            if ({Addr_FSM, DataIn_FSM} !== {16'(16'h1230 + 2 * k), 16'(16'hA000 + k)}) begin
               mismatched++;
               $display("FAIL stall_fill_word %0d: got %h/%h expected %h/%h", k, Addr_FSM, DataIn_FSM,
                        16'(16'h1230 + 2 * k), 16'(16'hA000 + k));
            end
            $display("stalled fill: word %0d addr %h data %h", k, Addr_FSM, DataIn_FSM);
            k++;
         end
         compared++;
         if (MetaData_WE !== (c == 14)) begin
            mismatched++;
            $display("FAIL stall_meta_we cycle %0d: got %b", c, MetaData_WE);
         end
         compared++;
         if ({Busy, Mem_En} !== {(c <= 14), (c >= 1 && c <= 8)}) begin
            mismatched++;
            $display("FAIL stall_busy_en cycle %0d: got %b%b", c, Busy, Mem_En);
         end
         step();
      end
      Mem_Valid = 1'b0;
      compared++;
      if (we_count !== 8) begin
         mismatched++;
         $display("FAIL stall_we_count: got %0d expected 8", we_count);
      end
   endtask

   // ------------------------------------------------------------------
   // Fill at 0102 with latency 1, one idle cycle, then a fill at FFF0.
   task automatic test_back_to_back();
      logic exp_en, exp_we;
      logic [15:0] exp_maddr, exp_faddr;
      for (int c = 0; c <= 23; c++) begin
         Miss      = !(c == 11 || c == 23);
         Miss_Addr = (c <= 11) ? 16'h0102 : 16'hFFF0;
         Mem_Valid = (c >= 2 && c <= 9) || (c >= 14 && c <= 21);
         Mem_Data  = 16'(16'hB000 + c);
         #2;
         exp_en    = (c >= 1 && c <= 8) || (c >= 13 && c <= 20);
         exp_we    = Mem_Valid;
         exp_maddr = (c <= 11) ? 16'(16'h0100 + 2 * (c - 1)) : 16'(16'hFFF0 + 2 * (c - 13));
         exp_faddr = (c <= 11) ? 16'(16'h0100 + 2 * (c - 2)) : 16'(16'hFFF0 + 2 * (c - 14));
         compared++;
         if ({Mem_En, Data_WE, MetaData_WE, Busy} !==
             {exp_en, exp_we, (c == 10 || c == 22), !(c == 11 || c == 23)}) begin
            mismatched++;
            $display("FAIL b2b_ctrl cycle %0d: got %b%b%b%b expected %b%b%b%b", c, Mem_En, Data_WE, MetaData_WE, Busy,
                     exp_en, exp_we, (c == 10 || c == 22), !(c == 11 || c == 23));
         end
         if (exp_en) begin
            compared++;
            if (Mem_Addr !== exp_maddr) begin
               mismatched++;
               $display("FAIL b2b_mem_addr cycle %0d: got %h expected %h", c, Mem_Addr, exp_maddr);
            end
         end
         if (exp_we) begin
            compared++;
            if ({Addr_FSM, DataIn_FSM} !== {exp_faddr, 16'(16'hB000 + c)}) begin
               mismatched++;
               $display("FAIL b2b_fill_word cycle %0d: got %h/%h expected %h/%h", c, Addr_FSM, DataIn_FSM,
                        exp_faddr, 16'(16'hB000 + c));
            end
            $display("back-to-back: word addr %h data %h", Addr_FSM, DataIn_FSM);
         end
         if (c == 10 || c == 22) begin
            compared++;
            if (Addr_FSM !== ((c == 10) ? 16'h0100 : 16'hFFF0)) begin
               mismatched++;
               $display("FAIL b2b_meta_addr cycle %0d: got %h", c, Addr_FSM);
            end
         end
         step();
      end
      Mem_Valid = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Reset after the fourth word of a fill at 5678, then a clean restart.
   task automatic test_reset_mid_fill();
      for (int c = 0; c <= 6; c++) begin
         Miss      = 1'b1;
         Miss_Addr = 16'h5678;
         Mem_Valid = (c >= 3);
         Mem_Data  = 16'(16'hC000 + c);
         #2;
         compared++;
         if (Data_WE !== (c >= 3)) begin
            mismatched++;
            $display("FAIL midrst_data_we cycle %0d: got %b", c, Data_WE);
         end
         step();
      end
      Miss = 1'b0;
      Mem_Valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      compared++;
      if (out_vec() !== 52'h0) begin
         mismatched++;
         $display("FAIL midrst_async_clear: got %h expected 0", out_vec());
      end
      for (int c = 0; c < 3; c++) begin
         step();
         #2;
         compared++;
         if (MetaData_WE !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_meta_in_reset cycle %0d: got %b", c, MetaData_WE);
         end
      end
      step();
      rst_n = 1'b1;
      #2;
      compared++;
      if ({Busy, MetaData_WE, Mem_En} !== 3'b000) begin
         mismatched++;
         $display("FAIL midrst_after_release: got %b expected 000", {Busy, MetaData_WE, Mem_En});
      end
      step();
      Miss = 1'b1;
      Miss_Addr = 16'h5678;
      step();
      #2;
      compared++;
      if ({Mem_En, Mem_Addr} !== {1'b1, 16'h5670}) begin
         mismatched++;
         $display("FAIL midrst_restart_req: got %b/%h expected 1/5670", Mem_En, Mem_Addr);
      end
      step();
      Mem_Valid = 1'b1;
      Mem_Data  = 16'h1111;
      #2;
      compared++;
      if ({Data_WE, Addr_FSM, DataIn_FSM} !== {1'b1, 16'h5670, 16'h1111}) begin
         mismatched++;
         $display("FAIL midrst_restart_word: got %b/%h/%h expected 1/5670/1111", Data_WE, Addr_FSM, DataIn_FSM);
      end
      $display("reset mid-fill: restart word addr %h data %h", Addr_FSM, DataIn_FSM);
      Mem_Valid = 1'b0;
      Miss = 1'b0;
      rst_n = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_stalled_memory();
      test_back_to_back();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
